// File: rtl/counter_display_scanner.sv
// counter_display_scanner: registers the ones digit from an upstream counter,
// counts its wrap pulses into a tens digit, and time-multiplexes both digits
// onto a 2-digit common-anode 7-segment display with optional leading-zero blanking.
module counter_display_scanner #(
   parameter int REFRESH_DIV = 16,
   parameter int TENS_MAX    = 9,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit_in,
   input  logic       clr_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic [3:0] tens_out,
   output logic       ovf_out
);

   localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [3:0]       TENS_LAST = 4'(TENS_MAX);

   logic [3:0]       r_ones;
   logic [3:0]       r_tens;
   logic             r_clr_prev;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sel;
   logic             w_inc;
   logic [3:0]       w_digit;

   // Active-low gfedcba decode; values above 9 show as hex glyphs.
   function automatic logic [6:0] dec7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Rising edge of the wrap level; clr_prev cleared by reset so a level
   // already high right after reset still counts once.
   assign w_inc = clr_in & ~r_clr_prev;

   // Ones capture, wrap edge detection, tens counting and overflow pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ones     <= 4'd0;
         r_tens     <= 4'd0;
         r_clr_prev <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_ones     <= digit_in;
         r_clr_prev <= clr_in;
         r_ovf      <= 1'b0;
         if (w_inc) begin
            if (r_tens == TENS_LAST) begin
               r_tens <= 4'd0;
               r_ovf  <= 1'b1;
            end else begin
               r_tens <= r_tens + 4'd1;
            end
         end
      end
   end

   // Scan timer: each digit stays selected for REFRESH_DIV cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
         r_sel <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
         r_sel <= ~r_sel;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_digit = r_sel ? r_tens : r_ones;

   // Anode/segment mux from registered state, with tens leading-zero blanking.
   always_comb begin
      an  = r_sel ? 2'b01 : 2'b10;
      seg = dec7(w_digit);
      if (r_sel && BLANK_LZ && (r_tens == 4'd0)) begin
         an  = 2'b11;
         seg = 7'b1111111;
      end
   end

   assign tens_out = r_tens;
   assign ovf_out  = r_ovf;

endmodule

// File: tb/tb_counter_display_scanner.sv
// Directed bench for counter_display_scanner: two instances share stimulus,
// one with leading-zero blanking and one without.
module tb_counter_display_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] digit_in;
   logic       clr_in;
   logic [6:0] seg,  seg2;
   logic [1:0] an,   an2;
   logic [3:0] tens_out, tens_out2;
   logic       ovf_out,  ovf_out2;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;   // edges since last reset edge

   counter_display_scanner #(.REFRESH_DIV(16), .TENS_MAX(9), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .reset(reset), .digit_in(digit_in), .clr_in(clr_in),
      .seg(seg), .an(an), .tens_out(tens_out), .ovf_out(ovf_out)
   );

   counter_display_scanner #(.REFRESH_DIV(16), .TENS_MAX(9), .BLANK_LZ(1'b0)) dut2 (
      .clk(clk), .reset(reset), .digit_in(digit_in), .clr_in(clr_in),
      .seg(seg2), .an(an2), .tens_out(tens_out2), .ovf_out(ovf_out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b (cyc=%0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock edge, then settle; reset edges restart the scan model.
   task automatic step();
      @(posedge clk);
      #1;
      if (!reset) cyc = 0;
      else        cyc++;
   endtask

   // Advance until the scan model reaches the given counter value and select.
   task automatic goto_win(input int cnt, input int sel);
      for (int k = 0; k < 64; k++) begin
         if ((cyc % 16) == cnt && ((cyc / 16) % 2) == sel) break;
         step();
      end
   endtask

   task automatic pulse_chk(input logic [3:0] exp_tens, input logic exp_ovf);
      clr_in = 1'b1;
      step();
      check("pulse_tens", {4'd0, tens_out}, {4'd0, exp_tens});
      check("pulse_ovf",  {7'd0, ovf_out},  {7'd0, exp_ovf});
      clr_in = 1'b0;
      step();
      check("ovf_low", {7'd0, ovf_out}, 8'd0);
   endtask

   initial begin
      reset    = 1'b0;
      digit_in = 4'd7;
      clr_in   = 1'b1;

      // Reset held with active inputs
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_seg",  {1'b0, seg},      {1'b0, 7'b1000000});
         check("rst_an",   {6'd0, an},       {6'd0, 2'b10});
         check("rst_tens", {4'd0, tens_out}, 8'd0);
         check("rst_ovf",  {7'd0, ovf_out},  8'd0);
      end

      // Release: ones shows 5 after one edge, blank tens window in edges 16..31
      reset    = 1'b1;
      digit_in = 4'd5;
      clr_in   = 1'b0;
      step();
      check("ones5_seg", {1'b0, seg}, {1'b0, 7'b0010010});
      check("ones5_an",  {6'd0, an},  {6'd0, 2'b10});
      check("no_count",  {4'd0, tens_out}, 8'd0);
      while (cyc < 15) step();
      check("win0_end_an", {6'd0, an}, {6'd0, 2'b10});
      for (int i = 16; i < 32; i++) begin
         step();
         check("blank_an",  {6'd0, an},  {6'd0, 2'b11});
         check("blank_seg", {1'b0, seg}, {1'b0, 7'b1111111});
      end
      step();
      check("win0_again_an", {6'd0, an}, {6'd0, 2'b10});

      // Single-cycle pulse, then held level counts once
      clr_in = 1'b1;
      step();
      check("tens1", {4'd0, tens_out}, 8'd1);
      clr_in = 1'b0;
      step();
      clr_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("tens2_hold", {4'd0, tens_out}, 8'd2);
      end
      clr_in = 1'b0;
      step();
      check("tens2_after", {4'd0, tens_out}, 8'd2);
      goto_win(5, 1);
      check("tens2_an",  {6'd0, an},  {6'd0, 2'b01});
      check("tens2_seg", {1'b0, seg}, {1'b0, 7'b0100100});

      // Advance 2 -> 9 -> 0, then a full 10-pulse wrap from 0
      for (int t = 3; t <= 9; t++) pulse_chk(4'(t), 1'b0);
      pulse_chk(4'd0, 1'b1);
      for (int t = 1; t <= 9; t++) pulse_chk(4'(t), 1'b0);
      pulse_chk(4'd0, 1'b1);

      // Hex ones digit, and tens zero shown vs blanked
      digit_in = 4'hB;
      goto_win(3, 0);
      check("onesB_seg", {1'b0, seg}, {1'b0, 7'b0000011});
      check("onesB_an",  {6'd0, an},  {6'd0, 2'b10});
      goto_win(3, 1);
      check("lz0_an",  {6'd0, an2},  {6'd0, 2'b01});
      check("lz0_seg", {1'b0, seg2}, {1'b0, 7'b1000000});
      check("lz1_an",  {6'd0, an},   {6'd0, 2'b11});
      check("hexB_tens_show", {1'b0, seg}, {1'b0, 7'b1111111});

      // Reach tens=3 and stop mid tens window at refresh_cnt=9
      for (int t = 1; t <= 3; t++) pulse_chk(4'(t), 1'b0);
      goto_win(9, 1);
      check("pre_rst_tens", {4'd0, tens_out}, 8'd3);
      check("pre_rst_an",   {6'd0, an},       {6'd0, 2'b01});
      check("pre_rst_seg",  {1'b0, seg},      {1'b0, 7'b0110000});

      // One-cycle reset mid-scan with coincident clr_in
      reset  = 1'b0;
      clr_in = 1'b1;
      step();
      check("mid_rst_tens", {4'd0, tens_out}, 8'd0);
      check("mid_rst_an",   {6'd0, an},       {6'd0, 2'b10});
      check("mid_rst_seg",  {1'b0, seg},      {1'b0, 7'b1000000});
      reset  = 1'b1;
      clr_in = 1'b0;
      for (int i = 1; i < 16; i++) begin
         step();
         check("restart_an", {6'd0, an}, {6'd0, 2'b10});
      end
      step();
      check("restart_tens_an", {6'd0, an}, {6'd0, 2'b11});
      check("restart_tens2_an", {6'd0, an2}, {6'd0, 2'b01});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_display_scanner.md
Name: counter_display_scanner

Overview:
- Receiving end of the wrapping counter's interface: consumes its 4-bit digit value and its wrap (clr) pulse.
- Keeps a registered ones digit and counts wrap events into a tens digit.
- Time-multiplexes both digits onto a 2-digit common-anode 7-segment display.
- Sits between the counter and the board display pins; provides a carry/overflow pulse for further cascading.

Parameters:
- REFRESH_DIV, 16: clock cycles each digit stays lit before the scan switches (≥2).
- TENS_MAX, 9: last tens value before wrap to 0 (0..15).
- BLANK_LZ, 1: 1 = blank the tens digit while it is 0; 0 = always show it.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- digit_in  input  4  ones value from counter's display output.
- clr_in  input  1  wrap indication from counter's clr output (level).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit anodes, active-low; an[0] = ones, an[1] = tens.
- tens_out  output  4  current tens register (debug/cascade).
- ovf_out  output  1  one-cycle pulse when tens wraps TENS_MAX -> 0.

Behaviour:
- Reset (reset==0 at posedge) clears all state:
  - ones_q = 0, tens_q = 0, clr_prev = 0.
  - refresh_cnt = 0, sel = 0, ovf_out = 0.
  - Resulting outputs: an = 2'b10, seg = 7'b1000000 ("0"), tens_out = 0.
- Reset has priority over all other events, including mid-scan and coincident clr_in.
- Ones path: ones_q <= digit_in every non-reset cycle. Display latency is 1 clk.
- Tens path, rising-edge detect on clr_in:
  - clr_prev <= clr_in every cycle.
  - Increment condition: clr_in==1 && clr_prev==0.
  - clr_in held high for N cycles counts once.
  - clr_in already high on the first cycle after reset counts once.
  - On increment: if tens_q == TENS_MAX, tens_q <= 0 and ovf_out <= 1; otherwise tens_q <= tens_q+1 and ovf_out <= 0.
  - ovf_out is registered and is 0 on every cycle without a wrap.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and sel toggles.
  - Each digit is lit for exactly REFRESH_DIV cycles; the scan is independent of clr_in and digit_in.
- Output mux (combinational from registers):
  - sel==0: an = 2'b10, seg = dec(ones_q).
  - sel==1: an = 2'b01, seg = dec(tens_q).
  - sel==1 && BLANK_LZ && tens_q==0: an = 2'b11, seg = 7'b1111111.
  - Exactly one anode is low, or none when blanked.
- dec (active-low, gfedcba):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
- Values above 9 display as hex; no saturation.
- Widths: tens_q is 4-bit. refresh_cnt is $clog2(REFRESH_DIV) bits. No arithmetic wraps other than those specified.

Test Plan:
- Reset low 3 cycles with digit_in=7, clr_in=1 -> seg=1000000, an=10, tens_out=0, ovf_out=0 throughout reset.
- Release reset, digit_in=5, clr_in=0 -> one cycle later, while sel=0, seg=0010010, an=10; cycles 16..31 after release an=11 (tens blanked, BLANK_LZ=1).
- Pulse clr_in for 1 cycle, then hold it high for 4 cycles -> tens_out goes 1 then 2 (two increments only); during the sel=1 window, an=01 and seg=0100100.
- Apply 10 separate clr_in pulses from tens=0 with TENS_MAX=9 -> tens_out 1..9, then 0; ovf_out high exactly one cycle, coincident with tens_out becoming 0.
- digit_in=4'hB -> ones window shows seg=0000011. With BLANK_LZ=0 and tens=0, the tens window shows an=01, seg=1000000.
- Assert reset for 1 cycle mid-scan (refresh_cnt=9, sel=1, tens=3) -> next cycle tens_out=0, an=10, and the scan restarts with the full 16-cycle ones window.
